// File: rtl/inst_fetch.sv
// Fetch stage: owns the fetch PC, drives the instruction ROM and
// buffers {pc, inst, misalign} entries in a small prefetch FIFO.
module inst_fetch #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [31:0]       rom_inst_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   input  logic              id_ready_i,
   output logic              id_valid_o,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [31:0]       id_inst_o,
   output logic              id_misalign_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(4);

   typedef enum logic [1:0] {IDLE, RUN, REDIR} state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] addr_q;
   logic              mis_pend;

   logic [ADDR_W-1:0] mem_pc   [DEPTH];
   logic [31:0]       mem_inst [DEPTH];
   logic              mem_mis  [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;

   logic empty, full, space, fetch, push, pop;

   assign empty = (count == '0);
   assign full  = (count == FULL);
   // A full FIFO still has room when decode drains the head this cycle.
   assign space = !full || id_ready_i;
   assign push  = fetch;
   assign pop   = !empty && id_ready_i && !branch_flag_i;

   always_comb begin
      state_nxt = state;
      fetch     = 1'b0;
      unique case (state)
         IDLE: state_nxt = RUN;
         RUN, REDIR: begin
            state_nxt = branch_flag_i ? REDIR : RUN;
            fetch     = space && !branch_flag_i;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rom_ce_o   = fetch;
   assign rom_addr_o = fetch ? fetch_pc : addr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         addr_q   <= '0;
         mis_pend <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i]   <= '0;
            mem_inst[i] <= '0;
            mem_mis[i]  <= 1'b0;
         end
      end else begin
         state <= state_nxt;
         if (branch_flag_i) begin
            fetch_pc <= {branch_target_i[ADDR_W-1:2], 2'b00};
            mis_pend <= |branch_target_i[1:0];
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
         end else begin
            if (push) begin
               mem_pc[wr_ptr]   <= fetch_pc;
               mem_inst[wr_ptr] <= rom_inst_i;
               mem_mis[wr_ptr]  <= mis_pend;
               wr_ptr           <= wr_ptr + PTR_ONE;
               fetch_pc         <= fetch_pc + STEP;
               addr_q           <= fetch_pc;
               mis_pend         <= 1'b0;
            end
            if (pop)
               rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
               count <= count + CNT_ONE;
            else if (pop && !push)
               count <= count - CNT_ONE;
         end
      end
   end

   assign id_valid_o    = !empty;
   assign id_pc_o       = empty ? '0 : mem_pc[rd_ptr];
   assign id_inst_o     = empty ? '0 : mem_inst[rd_ptr];
   assign id_misalign_o = empty ? 1'b0 : mem_mis[rd_ptr];

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Fetch stage directly upstream of the instruction ROM and downstream-feeding the decode stage.
- Owns the fetch PC.
- Drives the ROM chip-enable and address, and captures the ROM's combinational instruction word in the same cycle.
- Buffers {pc, inst} pairs in a small prefetch FIFO, so that decode back-pressure and branch redirects do not stall ROM access timing.

Parameters:
- ADDR_W, 32, width of PC and ROM address.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rom_ce_o  output  1  ROM chip enable; 1 = fetch this cycle.
- rom_addr_o  output  ADDR_W  byte address of the fetched word; bits [1:0] always 0.
- rom_inst_i  input  32  ROM data, valid combinationally in the same cycle as rom_ce_o/rom_addr_o; already byte-swapped by the ROM.
- branch_flag_i  input  1  redirect request from EX (one-cycle pulse).
- branch_target_i  input  ADDR_W  redirect address.
- id_ready_i  input  1  decode accepts the head entry this cycle.
- id_valid_o  output  1  head entry valid.
- id_pc_o  output  ADDR_W  PC of the head entry.
- id_inst_o  output  32  instruction of the head entry.
- id_misalign_o  output  1  head entry came from a redirect target with bits [1:0] != 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - Reset values: fetch_pc=RESET_PC, FIFO empty, state=IDLE.
  - Output reset values: rom_ce_o=0, rom_addr_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, id_misalign_o=0.
  - Reset asserted mid-operation discards all buffered entries immediately.
- States: IDLE, RUN, REDIR.
  - IDLE: one cycle after reset release. rom_ce_o=0. Next state is RUN.
  - RUN: ROM fetch is issued on any cycle where space is available.
    - Space available means count < DEPTH, or count == DEPTH and id_ready_i=1 (simultaneous pop frees a slot).
    - When issuing: rom_ce_o=1, rom_addr_o=fetch_pc. At the clock edge, {fetch_pc, rom_inst_i, misalign_pending} is pushed and fetch_pc <= fetch_pc+4.
    - fetch_pc wraps modulo 2^ADDR_W; there is no special handling at the wrap.
  - No space: rom_ce_o=0, rom_addr_o holds its last value, fetch_pc holds.
  - branch_flag_i=1 in any state except IDLE:
    - In that cycle: rom_ce_o=0, no push, and any pop is ignored.
    - At the clock edge: FIFO cleared (count=0) and fetch_pc <= {branch_target_i[ADDR_W-1:2], 2'b00}.
    - misalign_pending <= (branch_target_i[1:0] != 0). State goes to REDIR.
  - REDIR: behaves as RUN, fetching the target. misalign_pending clears after the first push.
    - Next state is RUN unless branch_flag_i is asserted again, in which case it stays in REDIR with the new target.
  - branch_flag_i in IDLE: is taken the same way (flush, new fetch_pc); the IDLE→RUN timing is unchanged.
- FIFO:
  - Registered storage, with read/write pointers of log2(DEPTH) bits that wrap naturally and a count of log2(DEPTH)+1 bits.
  - id_valid_o = (count != 0). id_pc_o, id_inst_o and id_misalign_o come from the head entry; when empty they are 0.
  - Pop occurs when id_valid_o && id_ready_i && !branch_flag_i.
  - Push and pop together leave count unchanged.
  - No push ever occurs when the FIFO is full without a pop; no overflow is possible. Pop on empty is ignored.
- Latency:
  - ROM word fetched in cycle N appears at the FIFO head in cycle N+1 if the FIFO was empty.
  - After reset release: first fetch in cycle 1, id_valid_o=1 in cycle 2.
  - After a redirect: the target word is fetched one cycle after the branch cycle and is valid at decode two cycles after it.
- Throughput: one instruction per cycle sustained while id_ready_i=1.

Test Plan:
- Reset release, id_ready_i=1 held → rom_addr_o sequence 0,4,8,12…; id_valid_o rises 2 cycles after release; id_pc_o/id_inst_o then match the ROM contents one per cycle.
- id_ready_i=0 from reset → exactly 4 fetches (pc 0..12), then rom_ce_o=0 and count=4. Raise id_ready_i for 1 cycle → one pop and one fetch (pc 16) in the same cycle, count stays 4.
- FIFO holding 3 entries, branch_flag_i=1 with target 0x100 and id_ready_i=1 → no pop, FIFO empty next cycle, next rom_addr_o=0x100, id_pc_o=0x100 two cycles after the branch, then 0x104.
- Redirect to 0x102 → rom_addr_o=0x100; head entry has id_misalign_o=1 and id_pc_o=0x100; the following entry (0x104) has id_misalign_o=0.
- Two branch pulses on consecutive cycles (targets 0x40, then 0x80) → no fetch of 0x40 is delivered; first delivered id_pc_o=0x80.
- fetch_pc preloaded via redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000. rst pulsed low mid-stream → id_valid_o=0 immediately (asynchronous), restart from RESET_PC.
